// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator tile loaders: FSM encoding and
// beat geometry helpers.
package accel_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DATA_WIDTH_DEFAULT = 256;
    localparam int BEAT_BYTES         = DATA_WIDTH_DEFAULT / 8;

    typedef struct packed {
        logic [15:0] rows;
        logic [7:0]  beats;
    } tile_shape_t;

    // 16 x 8 bit product always fits the 24-bit beat count.
    function automatic logic [23:0] tile_beats(input tile_shape_t shape);
        return {8'd0, shape.rows} * {16'd0, shape.beats};
    endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Strided 2-D read address walker: beat/row counters, row base accumulator
// and the count of requests issued so far.
module dma_addr_gen
    import accel_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int STEP_BYTES     = BEAT_BYTES
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] cmd_base,
    input  logic [MEM_ADDR_WIDTH-1:0] cmd_stride,
    input  logic [7:0]                cmd_beats,
    input  logic                      req_fire,
    output logic [MEM_ADDR_WIDTH-1:0] req_addr,
    output logic [23:0]               issued
);

    logic [MEM_ADDR_WIDTH-1:0] row_base;
    logic [MEM_ADDR_WIDTH-1:0] row_stride;
    logic [7:0]                beat;
    logic [7:0]                beats_per_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            row_base      <= '0;
            row_stride    <= '0;
            beat          <= '0;
            beats_per_row <= '0;
            issued        <= '0;
        end else if (start) begin
            row_base      <= cmd_base;
            row_stride    <= cmd_stride;
            beat          <= '0;
            beats_per_row <= cmd_beats;
            issued        <= '0;
        end else if (req_fire) begin
            issued <= issued + 24'd1;
            if (beat == beats_per_row - 8'd1) begin
                beat     <= '0;
                row_base <= row_base + row_stride;
            end else begin
                beat <= beat + 8'd1;
            end
        end
    end

    // Address arithmetic wraps modulo the memory address width.
    assign req_addr = row_base + MEM_ADDR_WIDTH'(beat) * MEM_ADDR_WIDTH'(STEP_BYTES);

endmodule

// File: rtl/scratchpad_dma_loader.sv
// Loads one strided 2-D tile from system memory into consecutive scratchpad
// lines and optionally signals a buffer swap on error-free completion.
module scratchpad_dma_loader
    import accel_pkg::*;
#(
    parameter int ADDR_WIDTH      = 14,
    parameter int DATA_WIDTH      = 256,
    parameter int MEM_ADDR_WIDTH  = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [MEM_ADDR_WIDTH-1:0] cmd_mem_base,
    input  logic [15:0]               cmd_rows,
    input  logic [7:0]                cmd_beats_per_row,
    input  logic [MEM_ADDR_WIDTH-1:0] cmd_row_stride,
    input  logic [ADDR_WIDTH-1:0]     cmd_sp_base,
    input  logic                      cmd_swap,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [MEM_ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                      mem_rsp_valid,
    output logic                      mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0]     mem_rsp_data,
    input  logic                      mem_rsp_err,
    output logic                      dma_wr_en,
    output logic [ADDR_WIDTH-1:0]     dma_wr_addr,
    output logic [DATA_WIDTH-1:0]     dma_wr_data,
    input  logic                      dma_wr_ready,
    output logic                      buffer_swap,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [1:0]                state
);

    localparam logic [3:0] OUT_LIMIT = 4'(MAX_OUTSTANDING);

    logic [23:0]           total;
    logic [23:0]           received;
    logic [23:0]           issued;
    logic [3:0]            outstanding;
    logic [ADDR_WIDTH-1:0] sp_base;
    logic                  swap_req;
    logic                  cmd_fire;
    logic                  req_fire;
    logic                  rsp_fire;
    logic                  last_rsp;
    logic [23:0]           cmd_total;

    logic                  wr_vld_p1;
    logic [ADDR_WIDTH-1:0] wr_addr_p1;
    logic [DATA_WIDTH-1:0] wr_data_p1;

    assign cmd_total     = tile_beats('{rows: cmd_rows, beats: cmd_beats_per_row});
    assign cmd_ready     = (state == ST_IDLE);
    assign cmd_fire      = cmd_valid && cmd_ready;
    assign mem_req_valid = (state == ST_RUN) && (issued < total) && (outstanding < OUT_LIMIT);
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign mem_rsp_ready = (state == ST_RUN) && dma_wr_ready;
    assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
    assign last_rsp      = rsp_fire && (received == total - 24'd1);
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);
    assign buffer_swap   = done && swap_req && !error;

    dma_addr_gen #(
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH),
        .STEP_BYTES     (DATA_WIDTH / 8)
    ) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .start      (cmd_fire),
        .cmd_base   (cmd_mem_base),
        .cmd_stride (cmd_row_stride),
        .cmd_beats  (cmd_beats_per_row),
        .req_fire   (req_fire),
        .req_addr   (mem_req_addr),
        .issued     (issued)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            total       <= '0;
            received    <= '0;
            outstanding <= '0;
            error       <= 1'b0;
            sp_base     <= '0;
            swap_req    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        total       <= cmd_total;
                        received    <= '0;
                        outstanding <= '0;
                        error       <= 1'b0;
                        sp_base     <= cmd_sp_base;
                        swap_req    <= cmd_swap;
                        state       <= (cmd_total == 24'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rsp_fire) begin
                        received <= received + 24'd1;
                        if (mem_rsp_err) begin
                            error <= 1'b1;
                        end
                    end
                    // Simultaneous issue and return leaves the in-flight count unchanged.
                    case ({req_fire, rsp_fire})
                        2'b10:   outstanding <= outstanding + 4'd1;
                        2'b01:   outstanding <= outstanding - 4'd1;
                        default: outstanding <= outstanding;
                    endcase
                    if (last_rsp) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Write stage p1: errored beats still consume a line position.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            wr_data_p1 <= '0;
        end else begin
            wr_vld_p1 <= rsp_fire && !mem_rsp_err;
            if (rsp_fire && !mem_rsp_err) begin
                wr_addr_p1 <= sp_base + ADDR_WIDTH'(received);
                wr_data_p1 <= mem_rsp_data;
            end
        end
    end

    assign dma_wr_en   = wr_vld_p1;
    assign dma_wr_addr = wr_addr_p1;
    assign dma_wr_data = wr_data_p1;

endmodule

// File: tb/tb_scratchpad_dma_loader.sv
// Bench for scratchpad_dma_loader: table-driven tile commands, hand-written
// corner sequences and randomized commands against a tile-walk reference model.
module tb_scratchpad_dma_loader;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_mem_base;
    logic [15:0]  cmd_rows;
    logic [7:0]   cmd_beats_per_row;
    logic [31:0]  cmd_row_stride;
    logic [13:0]  cmd_sp_base;
    logic         cmd_swap;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic [31:0]  mem_req_addr;
    logic         mem_rsp_valid;
    logic         mem_rsp_ready;
    logic [255:0] mem_rsp_data;
    logic         mem_rsp_err;
    logic         dma_wr_en;
    logic [13:0]  dma_wr_addr;
    logic [255:0] dma_wr_data;
    logic         dma_wr_ready;
    logic         buffer_swap;
    logic         busy;
    logic         done;
    logic         error;
    logic [1:0]   state;

    scratchpad_dma_loader dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_mem_base      (cmd_mem_base),
        .cmd_rows          (cmd_rows),
        .cmd_beats_per_row (cmd_beats_per_row),
        .cmd_row_stride    (cmd_row_stride),
        .cmd_sp_base       (cmd_sp_base),
        .cmd_swap          (cmd_swap),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_addr      (mem_req_addr),
        .mem_rsp_valid     (mem_rsp_valid),
        .mem_rsp_ready     (mem_rsp_ready),
        .mem_rsp_data      (mem_rsp_data),
        .mem_rsp_err       (mem_rsp_err),
        .dma_wr_en         (dma_wr_en),
        .dma_wr_addr       (dma_wr_addr),
        .dma_wr_data       (dma_wr_data),
        .dma_wr_ready      (dma_wr_ready),
        .buffer_swap       (buffer_swap),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .state             (state)
    );

    typedef struct {
        logic [15:0] rows;
        logic [7:0]  beats;
        logic [31:0] base;
        logic [31:0] stride;
        logic [13:0] sp;
        logic        swap;
        int          err_idx;
        int          wr_mode;
        int          req_mode;
        int          rsp_rand;
        int          has_exp;
        logic [31:0] exp_last_addr;
        logic [13:0] exp_last_line;
        int          exp_writes;
        logic        exp_swap;
    } vec_t;

    int vectors     = 0;
    int miscompares = 0;

    // Memory/monitor state, owned by the per-cycle process.
    logic [31:0]  rq[$];
    logic [31:0]  req_q[$];
    logic [13:0]  wr_addr_q[$];
    logic [255:0] wr_data_q[$];
    int           wr_due[$];
    int cyc          = 0;
    int rsp_cnt      = 0;
    int acc_cyc      = -10;
    int last_rsp_cyc = 0;
    int done_cyc     = 0;
    int done_cnt     = 0;
    int swap_cnt     = 0;
    int swap_bad     = 0;
    int lat_bad      = 0;
    int track_bad    = 0;
    int out_bad      = 0;
    logic err_after_acc = 1'b1;

    // Knobs and baselines, owned by the main sequence.
    int err_idx   = -1;
    int wr_mode   = 0;
    int req_mode  = 0;
    int rsp_rand  = 0;
    int rsp_limit = 32'h7fff_ffff;
    int rsp_start = 0;
    int req_start = 0;
    int wr_start  = 0;
    int done_start = 0;
    int swap_start = 0;

    vec_t tbl[6];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    function automatic logic [255:0] gen(input logic [31:0] a);
        logic [255:0] d;
        for (int k = 0; k < 8; k++) begin
            d[k*32 +: 32] = 32'(a * 32'(2*k + 1)) ^ 32'(32'h9E37_79B9 * 32'(k));
        end
        return d;
    endfunction

    function automatic logic [31:0] addr_of(input vec_t v, input int i);
        int r;
        int b;
        r = i / int'(v.beats);
        b = i % int'(v.beats);
        return v.base + 32'(r) * v.stride + 32'(b * 32);
    endfunction

    function automatic vec_t mk(input logic [15:0] rows, input logic [7:0] beats,
                                input logic [31:0] base, input logic [31:0] stride,
                                input logic [13:0] sp, input logic swap, input int err,
                                input int wrm, input logic [31:0] ela,
                                input logic [13:0] ell, input int ew, input logic es);
        vec_t v;
        v.rows = rows; v.beats = beats; v.base = base; v.stride = stride;
        v.sp = sp; v.swap = swap; v.err_idx = err; v.wr_mode = wrm;
        v.req_mode = 0; v.rsp_rand = 0; v.has_exp = 1;
        v.exp_last_addr = ela; v.exp_last_line = ell; v.exp_writes = ew; v.exp_swap = es;
        return v;
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Per-cycle memory model and monitor: drive at negedge, sample 1 ns later.
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        dma_wr_ready  = 1'b0;
        forever begin
            @(negedge clk);
            mem_req_ready = (req_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            case (wr_mode)
                0:       dma_wr_ready = 1'b1;
                1:       dma_wr_ready = ~dma_wr_ready;
                default: dma_wr_ready = 1'($urandom_range(0, 1));
            endcase
            mem_rsp_valid = (rq.size() > 0) && (rsp_cnt < rsp_limit) &&
                            ((rsp_rand == 0) || ($urandom_range(0, 2) != 0));
            if (mem_rsp_valid) begin
                mem_rsp_data = gen(rq[0]);
                mem_rsp_err  = ((rsp_cnt - rsp_start) == err_idx);
            end else begin
                mem_rsp_data = '0;
                mem_rsp_err  = 1'b0;
            end
            #1;
            if (rst) begin
                rq.delete();
                wr_due.delete();
            end else begin
                if (cmd_valid && cmd_ready) acc_cyc = cyc;
                if (cyc == acc_cyc + 1) err_after_acc = error;
                if (state == 2'd1 && mem_rsp_ready != dma_wr_ready) track_bad++;
                if (dma_wr_en) begin
                    wr_addr_q.push_back(dma_wr_addr);
                    wr_data_q.push_back(dma_wr_data);
                    if (wr_due.size() == 0) lat_bad++;
                    else begin
                        if (wr_due[0] != cyc) lat_bad++;
                        void'(wr_due.pop_front());
                    end
                end
                if (mem_rsp_valid && mem_rsp_ready) begin
                    if (!mem_rsp_err) wr_due.push_back(cyc + 1);
                    void'(rq.pop_front());
                    rsp_cnt++;
                    last_rsp_cyc = cyc;
                end
                if (mem_req_valid && mem_req_ready) begin
                    rq.push_back(mem_req_addr);
                    req_q.push_back(mem_req_addr);
                end
                if (rq.size() > 4) out_bad++;
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (buffer_swap) begin
                    swap_cnt++;
                    if (!done) swap_bad++;
                end
            end
            cyc++;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_state"}, 256'(state), 256'(0));
        check({tag, "_cmd_ready"}, 256'(cmd_ready), 256'(1));
        check({tag, "_req_valid"}, 256'(mem_req_valid), 256'(0));
        check({tag, "_req_addr"}, 256'(mem_req_addr), 256'(0));
        check({tag, "_rsp_ready"}, 256'(mem_rsp_ready), 256'(0));
        check({tag, "_wr_en"}, 256'(dma_wr_en), 256'(0));
        check({tag, "_wr_addr"}, 256'(dma_wr_addr), 256'(0));
        check({tag, "_wr_data"}, dma_wr_data, 256'(0));
        check({tag, "_swap"}, 256'(buffer_swap), 256'(0));
        check({tag, "_busy"}, 256'(busy), 256'(0));
        check({tag, "_done"}, 256'(done), 256'(0));
        check({tag, "_error"}, 256'(error), 256'(0));
    endtask

    task automatic start_cmd(input vec_t v);
        @(negedge clk);
        err_idx   = v.err_idx;
        wr_mode   = v.wr_mode;
        req_mode  = v.req_mode;
        rsp_rand  = v.rsp_rand;
        rsp_start = rsp_cnt;
        req_start = req_q.size();
        wr_start  = wr_addr_q.size();
        done_start = done_cnt;
        swap_start = swap_cnt;
        cmd_mem_base      = v.base;
        cmd_rows          = v.rows;
        cmd_beats_per_row = v.beats;
        cmd_row_stride    = v.stride;
        cmd_sp_base       = v.sp;
        cmd_swap          = v.swap;
        cmd_valid         = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input vec_t v, input string tag);
        int total;
        int nw;
        int k;
        logic exp_err;
        logic [31:0] ea;
        for (int i = 0; i < 800 && done_cnt == done_start; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #2;
        total   = int'(v.rows) * int'(v.beats);
        exp_err = (v.err_idx >= 0) && (v.err_idx < total);
        check({tag, "_done_count"}, 256'(done_cnt - done_start), 256'(1));
        check({tag, "_req_count"}, 256'(req_q.size() - req_start), 256'(total));
        for (int i = 0; i < total; i++) begin
            ea = addr_of(v, i);
            if (req_start + i < req_q.size()) check({tag, "_req_addr"}, 256'(req_q[req_start + i]), 256'(ea));
        end
        nw = 0;
        k  = wr_start;
        for (int i = 0; i < total; i++) begin
            if (i != v.err_idx) begin
                if (k < wr_addr_q.size()) begin
                    check({tag, "_wr_line"}, 256'(wr_addr_q[k]), 256'(14'(v.sp + 14'(i))));
                    check({tag, "_wr_data"}, wr_data_q[k], gen(addr_of(v, i)));
                end
                k++;
                nw++;
            end
        end
        check({tag, "_wr_count"}, 256'(wr_addr_q.size() - wr_start), 256'(nw));
        check({tag, "_swap_count"}, 256'(swap_cnt - swap_start), 256'(v.swap && !exp_err));
        check({tag, "_error_end"}, 256'(error), 256'(exp_err));
        check({tag, "_error_clear"}, 256'(err_after_acc), 256'(0));
        if (total > 0) check({tag, "_done_lat"}, 256'(done_cyc - last_rsp_cyc), 256'(2));
        else           check({tag, "_done_lat"}, 256'(done_cyc - acc_cyc), 256'(1));
        check({tag, "_idle"}, 256'(state), 256'(0));
        check({tag, "_monitors"}, 256'(swap_bad + lat_bad + track_bad + out_bad), 256'(0));
        if (v.has_exp != 0) begin
            check({tag, "_tbl_writes"}, 256'(wr_addr_q.size() - wr_start), 256'(v.exp_writes));
            check({tag, "_tbl_swap"}, 256'(swap_cnt - swap_start), 256'(v.exp_swap));
            if (req_q.size() > req_start) check({tag, "_tbl_last_addr"}, 256'(req_q[$]), 256'(v.exp_last_addr));
            if (wr_addr_q.size() > wr_start) check({tag, "_tbl_last_line"}, 256'(wr_addr_q[$]), 256'(v.exp_last_line));
        end
    endtask

    initial begin
        vec_t v;
        int total;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_mem_base = '0; cmd_rows = '0; cmd_beats_per_row = '0;
        cmd_row_stride = '0; cmd_sp_base = '0; cmd_swap = 1'b0;

        //            rows beats base        stride     sp        swp err wr last_addr    line      n  swap
        tbl[0] = mk(16'd1, 8'd4, 32'h1000, 32'h0,   14'd5,    1'b0, -1, 0, 32'h1060, 14'd8,    4, 1'b0);
        tbl[1] = mk(16'd3, 8'd2, 32'h2000, 32'h100, 14'd0,    1'b1, -1, 0, 32'h2220, 14'd5,    6, 1'b1);
        tbl[2] = mk(16'd2, 8'd3, 32'h40,   32'h80,  14'd10,   1'b0, -1, 1, 32'h100,  14'd15,   6, 1'b0);
        tbl[3] = mk(16'd1, 8'd4, 32'h3000, 32'h0,   14'd0,    1'b1,  2, 0, 32'h3060, 14'd3,    3, 1'b0);
        tbl[4] = mk(16'd0, 8'd5, 32'h4000, 32'h40,  14'd7,    1'b0, -1, 0, 32'h0,    14'd0,    0, 1'b0);
        tbl[5] = mk(16'd1, 8'd4, 32'h500,  32'h0,   14'h3FFE, 1'b1, -1, 2, 32'h560,  14'd1,    4, 1'b1);

        repeat (2) @(negedge clk);
        #2;
        check_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            start_cmd(tbl[i]);
            finish_cmd(tbl[i], $sformatf("tbl%0d", i));
        end

        // Outstanding limit: responses withheld, then released one at a time.
        v = mk(16'd1, 8'd8, 32'h8000, 32'h0, 14'd100, 1'b0, -1, 0, 32'h80E0, 14'd107, 8, 1'b0);
        rsp_limit = rsp_cnt;
        start_cmd(v);
        repeat (20) @(negedge clk);
        #2;
        check("outst_req_count", 256'(req_q.size() - req_start), 256'(4));
        check("outst_req_valid", 256'(mem_req_valid), 256'(0));
        rsp_limit = rsp_cnt + 1;
        repeat (6) @(negedge clk);
        #2;
        check("outst_one_rsp", 256'(rsp_cnt - rsp_start), 256'(1));
        check("outst_one_slot", 256'(req_q.size() - req_start), 256'(5));
        check("outst_req_valid2", 256'(mem_req_valid), 256'(0));
        rsp_limit = 32'h7fff_ffff;
        finish_cmd(v, "outst");

        // Reset in the middle of a transfer.
        v = mk(16'd2, 8'd4, 32'h9000, 32'h200, 14'd20, 1'b1, -1, 0, 32'h0, 14'd0, 0, 1'b0);
        start_cmd(v);
        repeat (3) @(negedge clk);
        #2;
        check("midrst_busy_before", 256'(busy), 256'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check_reset("midrst");
        rst = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        check("midrst_no_done", 256'(done_cnt - done_start), 256'(0));
        check("midrst_no_swap", 256'(swap_cnt - swap_start), 256'(0));
        check("midrst_idle", 256'(state), 256'(0));

        for (int t = 0; t < 24; t++) begin
            v.rows     = 16'($urandom_range(0, 3));
            v.beats    = 8'($urandom_range(0, 5));
            v.base     = {$urandom(), 5'b0} >> 5 << 5;
            v.stride   = 32'($urandom_range(0, 4095)) << 5;
            v.sp       = 14'($urandom());
            v.swap     = 1'($urandom_range(0, 1));
            v.wr_mode  = $urandom_range(0, 2);
            v.req_mode = $urandom_range(0, 1);
            v.rsp_rand = $urandom_range(0, 1);
            v.has_exp  = 0;
            total      = int'(v.rows) * int'(v.beats);
            v.err_idx  = (total > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, total - 1) : -1;
            start_cmd(v);
            finish_cmd(v, $sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scratchpad_dma_loader.md
# scratchpad_dma_loader

Tile loader that sits directly upstream of the scratchpad SRAM's DMA write port. It accepts one strided 2-D transfer command, issues 256-bit read requests to system memory, and writes the returned beats into consecutive scratchpad lines. It can pulse `buffer_swap` on completion, so the matrix access controller picks up the freshly filled buffer.

## Interface
- `ADDR_WIDTH`, 14: scratchpad line address width.
- `DATA_WIDTH`, 256: beat width; byte step per beat = DATA_WIDTH/8 = 32.
- `MEM_ADDR_WIDTH`, 32: system memory byte address width.
- `MAX_OUTSTANDING`, 4: maximum read requests in flight (1..15).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid` / `cmd_ready`  in / out  1  command handshake.
- `cmd_mem_base`  in  32  byte address of row 0, beat 0 (32 B aligned).
- `cmd_rows`  in  16  number of rows.
- `cmd_beats_per_row`  in  8  beats per row.
- `cmd_row_stride`  in  32  byte distance between row starts.
- `cmd_sp_base`  in  ADDR_WIDTH  first scratchpad line.
- `cmd_swap`  in  1  pulse `buffer_swap` on error-free completion.
- `mem_req_valid` / `mem_req_ready`  out / in  1  read request handshake.
- `mem_req_addr`  out  32  request byte address.
- `mem_rsp_valid` / `mem_rsp_ready`  in / out  1  response handshake; responses return in order.
- `mem_rsp_data`  in  DATA_WIDTH  beat data.
- `mem_rsp_err`  in  1  beat error flag.
- `dma_wr_en`  out  1  scratchpad write strobe.
- `dma_wr_addr`  out  ADDR_WIDTH  scratchpad write line.
- `dma_wr_data`  out  DATA_WIDTH  scratchpad write data.
- `dma_wr_ready`  in  1  scratchpad can accept a write.
- `buffer_swap`  out  1  one-cycle pulse to the scratchpad.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  sticky; set by any `mem_rsp_err`; cleared on the next command accept.
- `state`  out  2  current state.

## Operation
- States: IDLE=0, RUN=1, FLUSH=2, DONE=3.
- **IDLE:**
  - `cmd_ready`=1.
  - On handshake: latch all fields, compute total = rows*beats (24 bit), clear counters and `error`.
  - If total==0, go to DONE; otherwise go to RUN.
- **RUN, request side:**
  - `mem_req_valid` = (issued < total) && (outstanding < MAX_OUTSTANDING).
  - `mem_req_addr` = row_base + beat*32.
  - On handshake: increment beat. At beat==beats-1, beat←0 and row_base += row_stride.
- **RUN, response side:**
  - `mem_rsp_ready` = `dma_wr_ready`.
  - On handshake: received++ and outstanding--.
  - If !err: the next cycle drives `dma_wr_en`=1, `dma_wr_addr` = sp_base + received, `dma_wr_data` = the beat.
  - If err: the beat is consumed, nothing is written, and `error`←1. The scratchpad address still advances, so later beats keep their positions.
- Request and response handshakes in the same cycle leave outstanding unchanged.
- Arithmetic:
  - Memory address is mod 2^32.
  - Scratchpad address is mod 2^ADDR_WIDTH; it wraps silently.
  - Outstanding counter is 4 bits.
- When the final response is accepted, go RUN→FLUSH. The last write is on the bus during FLUSH.
- FLUSH→DONE unconditionally.
- **DONE:**
  - `done`=1.
  - `buffer_swap` = `cmd_swap` && !`error`.
  - Next state is IDLE.
- `cmd_valid` outside IDLE is ignored (`cmd_ready`=0).

## Timing
- Reset values: state=IDLE, `cmd_ready`=1, and every other output 0, including `dma_wr_addr`, `dma_wr_data` and `mem_req_addr`.
- Reset mid-transfer:
  - Return to IDLE immediately and discard counters.
  - No `done` and no `buffer_swap`.
  - The memory system must be reset in the same cycle.
- Response handshake at cycle N produces `dma_wr_en` at N+1.
- Final response at N: FLUSH at N+1, `done`/`buffer_swap` at N+2, IDLE at N+3.
- Zero-length command accepted at N: DONE at N+1, `done` pulse at N+1.
- `mem_req_valid`, `mem_req_addr`, `mem_rsp_ready` and `cmd_ready` are combinational from state and counters, with no input-to-output paths except `dma_wr_ready`→`mem_rsp_ready`.
- With `mem_req_ready`=1, `mem_rsp_valid`=1 and `dma_wr_ready`=1, throughput is 1 beat/cycle.

## Structure
- Shared package `accel_pkg`:
  - state encoding constants;
  - `BEAT_BYTES` = DATA_WIDTH/8.
- Sub-module `dma_addr_gen`: row/beat counters, row_base accumulator, request address and issued count.
- The top level holds the FSM, outstanding/received counters and write register.

## Test plan
- **Single contiguous row:** rows=1, beats=4, base=0x1000, sp_base=5, zero-latency memory.
  - Request addresses 0x1000, 0x1020, 0x1040, 0x1060.
  - Writes to lines 5–8 with matching data.
  - `done` 2 cycles after the last response.
- **Strided tile:** rows=3, beats=2, stride=0x100, base=0x2000.
  - Request addresses 0x2000, 0x2020, 0x2100, 0x2120, 0x2200, 0x2220.
  - With `cmd_swap`=1: exactly one `buffer_swap` pulse, coincident with `done`.
- **Outstanding limit:** `mem_rsp_valid` held low for 20 cycles.
  - Exactly 4 requests issued, then `mem_req_valid`=0.
  - One response frees exactly one request slot.
- **Backpressure:** toggle `dma_wr_ready` every cycle.
  - No beat lost or duplicated.
  - `mem_rsp_ready` tracks `dma_wr_ready`.
  - Line addresses stay contiguous.
- **Error beat:** error on beat 2 of 4, sp_base=0.
  - Lines 0, 1, 3 written; line 2 not written.
  - `error`=1, `done` pulses, `buffer_swap`=0.
  - Next command accept clears `error`.
- **Corner cases:**
  - rows=0: `done` one cycle after accept, no requests.
  - sp_base=0x3FFE, 4 beats: writes to lines 3FFE, 3FFF, 0, 1.
  - `rst` asserted mid-RUN: outputs return to reset values next cycle, no `done`.
